mor1kx_icache_refill_bus: RTL
=============================

// Module: mor1kx_icache_refill_bus
// PURPOSE
//  Bus-side refill engine for the instruction cache. Accepts the cache's refill request,
//  issues one Wishbone B3 burst read of a whole cache line and streams each returned word
//  back as a cache write (wradr/wrdat/we). Sits between the icache and the ibus Wishbone master port.
// PARAMETERS
//  OPTION_OPERAND_WIDTH       32  address/data width
//  OPTION_ICACHE_BLOCK_WIDTH  5   log2 line bytes; 5 -> 8 beats, 4 -> 4 beats (only 4/5 legal)
// PORTS
//  clk            in   1   clock, all logic on rising edge
//  rst_n          in   1   asynchronous reset, active low
//  refill_req_i   in   1   icache requests line refill (level)
//  refill_adr_i   in   OW  miss address (cpu_adr_match), byte address
//  refill_done_i  in   1   icache reports the final word of the line has been written
//  wradr_o        out  OW  cache write address (word aligned)
//  wrdat_o        out  32  cache write data
//  we_o           out  1   cache write strobe, one per accepted beat
//  imem_err_o     out  1   one-cycle pulse on bus error; routed to the icache error input
//  busy_o         out  1   engine not IDLE
//  ibus_adr_o     out  OW  Wishbone address
//  ibus_req_o     out  1   Wishbone cyc&stb
//  ibus_cti_o     out  3   3'b010 burst beats, 3'b111 final beat
//  ibus_bte_o     out  2   burst type extension
//  ibus_dat_i     in   32  read data
//  ibus_ack_i     in   1   beat acknowledge
//  ibus_err_i     in   1   bus error
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; ibus_req_o=0, ibus_adr_o=0, ibus_cti_o=0, ibus_bte_o=0,
//   imem_err_o=0, beat counter=0. we_o=0, busy_o=0 follow from IDLE. Reset mid-burst aborts immediately.
//  BEATS = 1<<(BLOCK_WIDTH-2). Word index = adr[BLOCK_WIDTH-1:2]; it increments modulo BEATS,
//   so the line-tag bits above BLOCK_WIDTH never change during a burst.
//  States:
//   IDLE : on refill_req_i=1, register start address (see CONFIGURATION). Set ibus_req_o=1,
//          beat counter=0. cti=010, or 111 when BEATS==1. Go to BURST (request to bus: 1 cycle).
//   BURST: the write-back path is combinational, zero latency: we_o=ibus_ack_i,
//          wrdat_o=ibus_dat_i, wradr_o=ibus_adr_o.
//          On ack: advance the word index (wrap) and increment the counter.
//           On the beat where the counter reaches BEATS-2, drive cti=111 for the following beat.
//           On the ack of the final beat (counter==BEATS-1): ibus_req_o=0 and go to DRAIN.
//          On ibus_err_i: ibus_req_o=0, imem_err_o=1 for 1 cycle, we_o=0, go to DRAIN.
//          If ack and err are both high in the same cycle, err wins and no write occurs.
//   DRAIN: exactly one cycle and refill_req_i is ignored, because the icache is leaving REFILL
//          and its request is stale. Then go to IDLE.
//  refill_done_i arriving before the final ack is a protocol violation. The engine continues
//   the burst and flags it in simulation with $display.
//  ibus_adr_o, ibus_cti_o and ibus_req_o are registered only; ibus_req_o never glitches.
//  Back-to-back misses: minimum gap is 1 idle bus cycle (DRAIN), plus the IDLE cycle.
// CONFIGURATION
//  MOR1KX_ICACHE_REFILL_WRAP_EN defined  : critical-word-first. Start at refill_adr_i word index;
//   ibus_bte_o = 2'b10 (8-beat wrap) for BLOCK_WIDTH=5, 2'b01 (4-beat wrap) for BLOCK_WIDTH=4.
//  MOR1KX_ICACHE_REFILL_WRAP_EN undefined: line-aligned linear burst. Start word index = 0;
//   ibus_bte_o = 2'b00. The icache's wrap-based done detection still works, since it ends on the
//   beat before the start index.
// STRUCTURE
//  Add to the shared mor1kx-defines header: state encodings (one-hot, 3 bits), Wishbone CTI codes
//   (CLASSIC/INC/EOB) and BTE codes (LINEAR/WRAP4/WRAP8).
//  One sub-module: mor1kx_wrap_counter (word index + beat count, modulo BEATS, with load/inc).
// TESTING
//  1 8-beat wrap: WRAP_EN, req adr 0x1014, ack every cycle -> adr 0x1014,18,1C,00,04,08,0C,10 (line
//    base 0x1000); 8 we_o; cti=111 only on 0x1010; bte=10.
//  2 Linear: no WRAP_EN, req adr 0x2008 -> adr 0x2000..0x201C in order, bte=00, start index 0.
//  3 Wait states: ack every 3rd cycle -> address holds between acks; exactly 8 we_o; data matches.
//  4 Error: err_i on beat 3 -> ibus_req_o low next cycle, imem_err_o=1 for one cycle,
//    3 writes total, back in IDLE two cycles later.
//  5 Stale request: refill_req_i held high through DRAIN -> no new burst starts until it is
//    seen again in IDLE.
//  6 Reset mid-burst: rst_n=0 at beat 5 -> all outputs zero immediately (async); a new request
//    after reset starts a clean burst.

Source files
------------

// File: rtl/mor1kx_icache_refill_bus_pkg.sv
// Shared definitions for the icache refill bus engine: FSM state encodings
// (one-hot), Wishbone B3 cycle-type (CTI) and burst-type (BTE) codes.
package mor1kx_icache_refill_bus_pkg;

  // One-hot engine states
  typedef enum logic [2:0] {
    REFILL_IDLE  = 3'b001,
    REFILL_BURST = 3'b010,
    REFILL_DRAIN = 3'b100
  } refill_state_t;

  // Wishbone cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Wishbone burst type extensions
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;

endpackage

// File: rtl/mor1kx_icache_refill_bus_wrap_counter.sv
// Word index and beat counter for one cache-line burst. Both count modulo
// 2**IW, so the index wraps inside the line and never carries into the tag.
module mor1kx_wrap_counter #(
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic [IW-1:0] load_idx,
  output logic [IW-1:0] idx,
  output logic [IW-1:0] cnt,
  output logic          last,
  output logic          penult
);

  localparam logic [IW-1:0] CNT_LAST   = '1;
  localparam logic [IW-1:0] CNT_PENULT = CNT_LAST - 1'b1;

  // Load starts a new line at the given index with zero beats done; inc advances both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      cnt <= '0;
    end else if (load) begin
      idx <= load_idx;
      cnt <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
      cnt <= cnt + 1'b1;
    end
  end

  assign last   = (cnt == CNT_LAST);
  assign penult = (cnt == CNT_PENULT);

endmodule

// File: rtl/mor1kx_icache_refill_bus.sv
// Bus-side icache refill engine: one Wishbone B3 burst per cache line, each
// acknowledged beat written straight back into the cache.
// Optional feature macro: MOR1KX_ICACHE_REFILL_WRAP_EN (critical-word-first
// wrapping burst). Without it the burst is line-aligned and linear.
//
// Handshake: ibus_req_o acts as valid and holds address/cti stable until the
// slave asserts ibus_ack_i (accept) or ibus_err_i (abort) in the same cycle;
// a beat transfers only on a cycle where req and ack are both high and err is low.
module mor1kx_icache_refill_bus
  import mor1kx_icache_refill_bus_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = 5   // only 4 or 5 are meaningful
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            refill_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
  input  logic                            refill_done_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
  output logic [31:0]                     wrdat_o,
  output logic                            we_o,
  output logic                            imem_err_o,
  output logic                            busy_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
  output logic                            ibus_req_o,
  output logic [2:0]                      ibus_cti_o,
  output logic [1:0]                      ibus_bte_o,
  input  logic [31:0]                     ibus_dat_i,
  input  logic                            ibus_ack_i,
  input  logic                            ibus_err_i
);

  localparam int OW    = OPTION_OPERAND_WIDTH;
  localparam int BW    = OPTION_ICACHE_BLOCK_WIDTH;
  localparam int IW    = BW - 2;
  localparam int BEATS = 1 << IW;
  localparam int TW    = OW - BW;
  localparam logic [2:0] START_CTI = (BEATS == 1) ? CTI_EOB : CTI_INC;

`ifdef MOR1KX_ICACHE_REFILL_WRAP_EN
  localparam logic [1:0] START_BTE = (BW == 5) ? BTE_WRAP8 : BTE_WRAP4;
`else
  localparam logic [1:0] START_BTE = BTE_LINEAR;
`endif

  refill_state_t state_q, state_d;
  logic          req_q, req_d;
  logic [2:0]    cti_q, cti_d;
  logic [1:0]    bte_q, bte_d;
  logic          err_q, err_d;
  logic [TW-1:0] tag_q, tag_d;

  logic          cnt_load, cnt_inc;
  logic [IW-1:0] start_idx, word_idx, beat_cnt;
  logic          last_beat, penult_beat;
  logic          unused_adr_bits;

`ifdef MOR1KX_ICACHE_REFILL_WRAP_EN
  assign start_idx = refill_adr_i[BW-1:2];
`else
  assign start_idx = '0;
`endif
  // Byte offset bits (and the index bits in the linear build) are don't-care
  assign unused_adr_bits = ^refill_adr_i[BW-1:0];

  mor1kx_wrap_counter #(.IW(IW)) u_wrap_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .inc      (cnt_inc),
    .load_idx (start_idx),
    .idx      (word_idx),
    .cnt      (beat_cnt),
    .last     (last_beat),
    .penult   (penult_beat)
  );

  // Next-state and next registered bus outputs; err beats ack when both arrive
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cti_d    = cti_q;
    bte_d    = bte_q;
    err_d    = 1'b0;
    tag_d    = tag_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      REFILL_IDLE: begin
        if (refill_req_i) begin
          tag_d    = refill_adr_i[OW-1:BW];
          cnt_load = 1'b1;
          req_d    = 1'b1;
          cti_d    = START_CTI;
          bte_d    = START_BTE;
          state_d  = REFILL_BURST;
        end
      end
      REFILL_BURST: begin
        if (ibus_err_i) begin
          req_d   = 1'b0;
          cti_d   = CTI_CLASSIC;
          err_d   = 1'b1;
          state_d = REFILL_DRAIN;
        end else if (ibus_ack_i) begin
          cnt_inc = 1'b1;
          if (last_beat) begin
            req_d   = 1'b0;
            cti_d   = CTI_CLASSIC;
            state_d = REFILL_DRAIN;
          end else if (penult_beat) begin
            cti_d = CTI_EOB;
          end
        end
      end
      // The icache's request is stale here, so it is deliberately ignored
      REFILL_DRAIN: state_d = REFILL_IDLE;
      default:      state_d = REFILL_IDLE;
    endcase
  end

  // State and registered bus-side outputs; async reset aborts any burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REFILL_IDLE;
      req_q   <= 1'b0;
      cti_q   <= CTI_CLASSIC;
      bte_q   <= BTE_LINEAR;
      err_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cti_q   <= cti_d;
      bte_q   <= bte_d;
      err_q   <= err_d;
      tag_q   <= tag_d;
    end
  end

  assign ibus_adr_o = {tag_q, word_idx, 2'b00};
  assign ibus_req_o = req_q;
  assign ibus_cti_o = cti_q;
  assign ibus_bte_o = bte_q;
  assign imem_err_o = err_q;
  assign busy_o     = (state_q != REFILL_IDLE);

  // Zero-latency write-back of each accepted beat
  assign we_o    = (state_q == REFILL_BURST) && ibus_ack_i && !ibus_err_i;
  assign wradr_o = ibus_adr_o;
  assign wrdat_o = (state_q == REFILL_BURST) ? ibus_dat_i : 32'h0;

  // The icache must not report line completion before the final beat is written
  a_done_not_early: assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == REFILL_BURST && refill_done_i &&
      !(ibus_ack_i && !ibus_err_i && last_beat)));

endmodule
